dds_key_ctrl: RTL and testbench
===============================

# dds_key_ctrl

Operator-input stage directly upstream of the DDS control block. It debounces three active-low push-buttons and maintains the one-hot waveform select and the 32-bit phase-increment word that the DDS phase accumulator consumes. It runs entirely in the 125 MHz PLL clock domain, so its outputs feed the DDS without any clock-domain crossing.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 2_500_000: consecutive stable cycles required to accept a key level change (20 ms at 125 MHz); must be ≥ 2.
- `F_WORD_INIT`, default 50: f_word value after reset.
- `F_WORD_STEP`, default 10: increment/decrement applied per key press.
- `F_WORD_MIN`, default 10: lower saturation bound.
- `F_WORD_MAX`, default 1000: upper saturation bound; F_WORD_MIN ≤ F_WORD_INIT ≤ F_WORD_MAX.

Ports:
- `clk_125m`, input, 1: system clock, 125 MHz PLL output.
- `sys_rst_n`, input, 1: reset, asynchronous, active-low.
- `key_wave`, input, 1: raw wave-cycle button, asynchronous, active-low (pressed = 0).
- `key_up`, input, 1: raw frequency-up button, active-low.
- `key_dn`, input, 1: raw frequency-down button, active-low.
- `wave_sel`, output, 4: one-hot: 0001 sine, 0010 square, 0100 triangle, 1000 sawtooth.
- `f_word`, output, 32: phase increment to the DDS accumulator.
- `cfg_valid`, output, 1: single-cycle pulse on any change of wave_sel or f_word.

## Operation
- Each key passes through a 2-flop synchronizer (reset value 1) and then a `key_debounce` instance.
- Debounce state machine, per key:
  - IDLE (released, debounced level 1) → PRESS_WAIT when the synced level is 0.
  - PRESS_WAIT → IDLE if the synced level returns to 1 before the count completes; the counter clears.
  - PRESS_WAIT → PRESSED after DEBOUNCE_CYCLES consecutive cycles at 0. This transition emits a 1-cycle `press` pulse.
  - PRESSED → RELEASE_WAIT when the synced level is 1.
  - RELEASE_WAIT → PRESSED if the level returns to 0 early; otherwise → IDLE after DEBOUNCE_CYCLES cycles at 1. Release emits no pulse.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1 bits. The counter clears on every state change.
- A key held down produces exactly one press event; there is no auto-repeat.
- Wave press: wave_sel rotates left, 0001→0010→0100→1000→0001. An illegal (non-one-hot) value never occurs; if it is forced, the next press loads 0001.
- Up press: f_word = min(f_word + F_WORD_STEP, F_WORD_MAX). Compute in 33 bits so the 32-bit sum cannot wrap.
- Down press: f_word = max(f_word − F_WORD_STEP, F_WORD_MIN). Compare before subtracting so the result cannot underflow.
- Up and down press in the same cycle: both are ignored and f_word is unchanged.
- Wave and frequency press in the same cycle: both are applied, with a single cfg_valid pulse.
- A press at a saturation bound leaves f_word unchanged, and cfg_valid is not asserted unless wave_sel also changed.
- Reset values: wave_sel = 4'b0001, f_word = F_WORD_INIT, cfg_valid = 0. All debouncers return to IDLE and all counters clear.
- Reset asserted mid-debounce aborts the pending event. After reset release, a key that is still held must complete a full DEBOUNCE_CYCLES window before it registers.

## Timing
- All outputs are registered.
- Latency: a clean key fall first sampled at edge N produces the press pulse at edge N+2+DEBOUNCE_CYCLES, and wave_sel/f_word/cfg_valid update at edge N+3+DEBOUNCE_CYCLES.
- cfg_valid is high for exactly the one cycle in which the new output values first appear.
- Minimum spacing between accepted presses of one key: 2×DEBOUNCE_CYCLES cycles (press window plus release window).
- Glitches shorter than DEBOUNCE_CYCLES cycles never change any output.

## Configuration
- `DDS_KEY_FREQ_ADJ_EN`:
  - Defined: key_up/key_dn debouncers and the f_word adjust logic are built as described above.
  - Undefined: key_up/key_dn are ignored (no debouncer instances), f_word is the constant F_WORD_INIT, and cfg_valid pulses only on wave_sel changes.

## Structure
- Shared package `dds_pkg`:
  - one-hot constants WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW;
  - F_WORD_W = 32;
  - the debounce state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
- Sub-module `key_debounce`: contains the synchronizer, counter and FSM, and outputs the `press` pulse. It is instantiated once per key (3× with the macro defined, 1× without).

## Test plan
All scenarios use DEBOUNCE_CYCLES = 16, F_WORD_INIT = 50, STEP = 10, MIN = 10, MAX = 70.
- Reset, then hold key_wave low for 40 cycles, release, and repeat 4 times → wave_sel goes 0010, 0100, 1000, 0001. Each update lands 19 cycles after the first low sample, with one cfg_valid pulse per press.
- key_up bouncing (low 5 cycles, high 3 cycles, ×4), then held low for 30 cycles → exactly one step, f_word = 60.
- Three clean key_up presses from 50 → f_word = 60, 70, 70. There is no cfg_valid pulse on the third press.
- Six key_dn presses from 50 → f_word goes 40, 30, 20, 10, then stays at 10. The last two presses give no cfg_valid.
- key_up and key_dn pressed on the same cycle together with key_wave → f_word stays 50, wave_sel = 0010, one cfg_valid pulse.
- Assert sys_rst_n at cycle 10 of a key_wave press while the key stays held; release reset → outputs show their reset values. wave_sel changes only after a further 19 cycles.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS operator-input path: waveform one-hot codes,
// phase-word width and the key debounce state encoding.
package dds_pkg;

    localparam int F_WORD_W = 32;

    localparam logic [3:0] WAVE_SINE   = 4'b0001;
    localparam logic [3:0] WAVE_SQUARE = 4'b0010;
    localparam logic [3:0] WAVE_TRI    = 4'b0100;
    localparam logic [3:0] WAVE_SAW    = 4'b1000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    // Any non-one-hot value recovers to sine on the next wave press.
    function automatic logic [3:0] wave_next(input logic [3:0] w);
        logic [3:0] nxt;
        case (w)
            WAVE_SINE:   nxt = WAVE_SQUARE;
            WAVE_SQUARE: nxt = WAVE_TRI;
            WAVE_TRI:    nxt = WAVE_SAW;
            WAVE_SAW:    nxt = WAVE_SINE;
            default:     nxt = WAVE_SINE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dds_key_ctrl_if.sv
// Key inputs and DDS configuration outputs of dds_key_ctrl; master is the
// key controller, slave is whoever drives the buttons and consumes the config.
interface dds_key_ctrl_if;
    import dds_pkg::*;

    logic                key_wave;
    logic                key_up;
    logic                key_dn;
    logic [3:0]          wave_sel;
    logic [F_WORD_W-1:0] f_word;
    logic                cfg_valid;

    modport master (
        input  key_wave,
        input  key_up,
        input  key_dn,
        output wave_sel,
        output f_word,
        output cfg_valid
    );

    modport slave (
        output key_wave,
        output key_up,
        output key_dn,
        input  wave_sel,
        input  f_word,
        input  cfg_valid
    );

endinterface

// File: rtl/key_debounce.sv
// One active-low push-button: 2-flop synchronizer, stable-level counter and a
// four-state FSM that emits a single-cycle press pulse per accepted press.
module key_debounce
    import dds_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_500_000
) (
    input  logic clk_125m,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Synchronizer stage: idles at the released level so reset never looks like a press.
    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!sync_p1) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (sync_p1) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (sync_p1) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!sync_p1) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Every window starts from zero, whichever way the state moved.
        if (state_d != state_q) cnt_d = '0;
    end

    assign press = press_q;

endmodule

// File: rtl/dds_key_ctrl.sv
// Debounced operator keys -> one-hot wave select and DDS phase-increment word.
// Frequency keys and f_word adjust exist only when DDS_KEY_FREQ_ADJ_EN is defined.
module dds_key_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
    parameter int unsigned F_WORD_INIT     = 50,
    parameter int unsigned F_WORD_STEP     = 10,
    parameter int unsigned F_WORD_MIN      = 10,
    parameter int unsigned F_WORD_MAX      = 1000
) (
    input  logic            clk_125m,
    input  logic            sys_rst_n,
    dds_key_ctrl_if.master  ctrl
);

    localparam int FX_W = F_WORD_W + 1;
    localparam logic [F_WORD_W-1:0] F_INIT_W = F_WORD_W'(F_WORD_INIT);
    localparam logic [FX_W-1:0]     STEP_X   = FX_W'(F_WORD_STEP);
    localparam logic [FX_W-1:0]     MIN_X    = FX_W'(F_WORD_MIN);
    localparam logic [FX_W-1:0]     MAX_X    = FX_W'(F_WORD_MAX);

    logic                press_wave_p0;
    logic [3:0]          wave_d;
    logic [3:0]          wave_p1;
    logic [F_WORD_W-1:0] f_word_d;
    logic [F_WORD_W-1:0] f_word_p1;
    logic                vld_p1;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_wave (
        .clk_125m  (clk_125m),
        .sys_rst_n (sys_rst_n),
        .key_n     (ctrl.key_wave),
        .press     (press_wave_p0)
    );

    always_comb begin
        wave_d = wave_p1;
        if (press_wave_p0) wave_d = wave_next(wave_p1);
    end

`ifdef DDS_KEY_FREQ_ADJ_EN
    logic press_up_p0;
    logic press_dn_p0;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_125m  (clk_125m),
        .sys_rst_n (sys_rst_n),
        .key_n     (ctrl.key_up),
        .press     (press_up_p0)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk_125m  (clk_125m),
        .sys_rst_n (sys_rst_n),
        .key_n     (ctrl.key_dn),
        .press     (press_dn_p0)
    );

    // Sum carried in one extra bit so a large word cannot wrap past the ceiling.
    function automatic logic [F_WORD_W-1:0] sat_up(input logic [F_WORD_W-1:0] f);
        logic [FX_W-1:0] sum;
        sum = {1'b0, f} + STEP_X;
        if (sum > MAX_X) return MAX_X[F_WORD_W-1:0];
        return sum[F_WORD_W-1:0];
    endfunction

    // Bound checked before subtracting, so the word never underflows.
    function automatic logic [F_WORD_W-1:0] sat_dn(input logic [F_WORD_W-1:0] f);
        if ({1'b0, f} >= (MIN_X + STEP_X)) return f - STEP_X[F_WORD_W-1:0];
        return MIN_X[F_WORD_W-1:0];
    endfunction

    always_comb begin
        f_word_d = f_word_p1;
        if (press_up_p0 && !press_dn_p0) begin
            f_word_d = sat_up(f_word_p1);
        end else if (press_dn_p0 && !press_up_p0) begin
            f_word_d = sat_dn(f_word_p1);
        end
    end

    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) f_word_p1 <= F_INIT_W;
        else            f_word_p1 <= f_word_d;
    end
`else
    logic unused_keys;

    assign unused_keys = ^{ctrl.key_up, ctrl.key_dn, STEP_X, MIN_X, MAX_X};
    assign f_word_d    = F_INIT_W;
    assign f_word_p1   = F_INIT_W;
`endif

    // Output stage: cfg_valid rises with the first cycle of any new value.
    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wave_p1 <= WAVE_SINE;
            vld_p1  <= 1'b0;
        end else begin
            wave_p1 <= wave_d;
            vld_p1  <= (wave_d != wave_p1) || (f_word_d != f_word_p1);
        end
    end

    assign ctrl.wave_sel  = wave_p1;
    assign ctrl.f_word    = f_word_p1;
    assign ctrl.cfg_valid = vld_p1;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl with a 16-cycle debounce window and a 10..70
// frequency range; frequency scenarios follow the DDS_KEY_FREQ_ADJ_EN build.
module tb_dds_key_ctrl;
    import dds_pkg::*;

    logic clk_125m  = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cfg_cnt   = 0;

    dds_key_ctrl_if dut_if ();

    dds_key_ctrl #(
        .DEBOUNCE_CYCLES (16),
        .F_WORD_INIT     (50),
        .F_WORD_STEP     (10),
        .F_WORD_MIN      (10),
        .F_WORD_MAX      (70)
    ) dut (
        .clk_125m  (clk_125m),
        .sys_rst_n (sys_rst_n),
        .ctrl      (dut_if)
    );

    always #4 clk_125m = ~clk_125m;

    always @(negedge clk_125m) begin
        if (dut_if.cfg_valid === 1'b1) cfg_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_125m);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        step(3);
        sys_rst_n = 1'b1;
        step(3);
    endtask

    task automatic press_keys(input logic w, input logic u, input logic d, input int hold);
        dut_if.key_wave = ~w;
        dut_if.key_up   = ~u;
        dut_if.key_dn   = ~d;
        step(hold);
        dut_if.key_wave = 1'b1;
        dut_if.key_up   = 1'b1;
        dut_if.key_dn   = 1'b1;
        step(40);
    endtask

    task automatic freq_press(input string tag, input logic u, input logic d,
                              input int exp_f, input int exp_pulses);
        int c0;
        c0 = cfg_cnt;
        press_keys(1'b0, u, d, 40);
        chk_eq({tag, "_f"}, dut_if.f_word, 32'(exp_f));
        chk_eq({tag, "_vld"}, 32'(cfg_cnt - c0), 32'(exp_pulses));
    endtask

    logic [3:0] wave_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         dn_seq   [6] = '{40, 30, 20, 10, 10, 10};
    int         dn_vld   [6] = '{1, 1, 1, 1, 0, 0};

    initial begin
        int c0;
        dut_if.key_wave = 1'b1;
        dut_if.key_up   = 1'b1;
        dut_if.key_dn   = 1'b1;
        step(3);
        chk_eq("rst_wave", 32'(dut_if.wave_sel), 32'h1);
        chk_eq("rst_f", dut_if.f_word, 32'd50);
        chk_eq("rst_vld", 32'(dut_if.cfg_valid), 32'd0);
        sys_rst_n = 1'b1;
        step(3);

        // First wave press with exact latency: update on the 19th edge after the first low sample.
        c0 = cfg_cnt;
        dut_if.key_wave = 1'b0;
        step(19);
        chk_eq("lat_before", 32'(dut_if.wave_sel), 32'h1);
        step(1);
        chk_eq("lat_wave", 32'(dut_if.wave_sel), 32'h2);
        chk_eq("lat_vld_hi", 32'(dut_if.cfg_valid), 32'd1);
        step(1);
        chk_eq("lat_vld_lo", 32'(dut_if.cfg_valid), 32'd0);
        step(19);
        dut_if.key_wave = 1'b1;
        step(40);
        for (int i = 1; i < 4; i++) begin
            press_keys(1'b1, 1'b0, 1'b0, 40);
            chk_eq($sformatf("wave_%0d", i), 32'(dut_if.wave_sel), 32'(wave_seq[i]));
        end
        chk_eq("wave_pulses", 32'(cfg_cnt - c0), 32'd4);

        c0 = cfg_cnt;
        press_keys(1'b1, 1'b0, 1'b0, 15);
        chk_eq("glitch_wave", 32'(dut_if.wave_sel), 32'h1);
        chk_eq("glitch_vld", 32'(cfg_cnt - c0), 32'd0);

`ifdef DDS_KEY_FREQ_ADJ_EN
        do_reset();
        c0 = cfg_cnt;
        repeat (4) begin
            dut_if.key_up = 1'b0;
            step(5);
            dut_if.key_up = 1'b1;
            step(3);
        end
        press_keys(1'b0, 1'b1, 1'b0, 30);
        chk_eq("bounce_f", dut_if.f_word, 32'd60);
        chk_eq("bounce_vld", 32'(cfg_cnt - c0), 32'd1);

        do_reset();
        freq_press("up1", 1'b1, 1'b0, 60, 1);
        freq_press("up2", 1'b1, 1'b0, 70, 1);
        freq_press("up3", 1'b1, 1'b0, 70, 0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            freq_press($sformatf("dn%0d", i + 1), 1'b0, 1'b1, dn_seq[i], dn_vld[i]);
        end
`else
        do_reset();
        freq_press("up_off", 1'b1, 1'b0, 50, 0);
        freq_press("dn_off", 1'b0, 1'b1, 50, 0);
`endif

        do_reset();
        c0 = cfg_cnt;
        press_keys(1'b1, 1'b1, 1'b1, 40);
        chk_eq("combo_f", dut_if.f_word, 32'd50);
        chk_eq("combo_wave", 32'(dut_if.wave_sel), 32'h2);
        chk_eq("combo_vld", 32'(cfg_cnt - c0), 32'd1);

        // Reset during a held press: the key must earn a full fresh window afterwards.
        do_reset();
        dut_if.key_wave = 1'b0;
        step(10);
        sys_rst_n = 1'b0;
        step(2);
        chk_eq("midrst_wave", 32'(dut_if.wave_sel), 32'h1);
        chk_eq("midrst_f", dut_if.f_word, 32'd50);
        chk_eq("midrst_vld", 32'(dut_if.cfg_valid), 32'd0);
        sys_rst_n = 1'b1;
        step(19);
        chk_eq("midrst_hold", 32'(dut_if.wave_sel), 32'h1);
        step(1);
        chk_eq("midrst_wave2", 32'(dut_if.wave_sel), 32'h2);
        chk_eq("midrst_vld2", 32'(dut_if.cfg_valid), 32'd1);
        dut_if.key_wave = 1'b1;
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
